time_set_ctrl_m: RTL and testbench

TIME_SET_CTRL_M -- requirements
Module: time_set_ctrl_m

---
 rtl/clock_pkg.sv | 21 ++
 rtl/time_step_m.sv | 26 ++
 rtl/time_set_ctrl_m.sv | 152 +++++++++++++++
 tb/tb_time_set_ctrl_m.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day types, constants and the set-mode state encoding.
package clock_pkg;

   typedef logic [16:0] COUNTER_T;
   typedef logic        FLAG_T;

   localparam COUNTER_T COUNTER_MAX   = 17'd86399;
   localparam COUNTER_T SECS_PER_HOUR = 17'd3600;
   localparam COUNTER_T SECS_PER_DAY  = 17'd86400;
   localparam COUNTER_T SECS_PER_MIN  = 17'd60;
   localparam COUNTER_T MINUTE_59     = 17'd3540;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_SET_HR  = 3'd1,
      ST_SET_MIN = 3'd2,
      ST_ALM_HR  = 3'd3,
      ST_ALM_MIN = 3'd4
   } state_e;

endpackage

// File: rtl/time_step_m.sv
// Combinational hour/minute stepping and seconds-zeroing of a seconds-of-day value.
module time_step_m
   import clock_pkg::*;
#(
   parameter COUNTER_T MAX_VAL = COUNTER_MAX
) (
   input  COUNTER_T value_i,
   output COUNTER_T hr_step_o,
   output COUNTER_T min_step_o,
   output COUNTER_T zero_sec_o
);

   logic [17:0] hr_sum;
   COUNTER_T    sec_in_hr;

   assign hr_sum    = {1'b0, value_i} + {1'b0, SECS_PER_HOUR};
   assign sec_in_hr = value_i % SECS_PER_HOUR;

   // Stepping past 23:xx folds back to 00:xx with minutes and seconds kept.
   assign hr_step_o  = (hr_sum > {1'b0, MAX_VAL}) ? COUNTER_T'(hr_sum - {1'b0, SECS_PER_DAY})
                                                  : hr_sum[16:0];
   assign min_step_o = (sec_in_hr >= MINUTE_59) ? (value_i - MINUTE_59)
                                                : (value_i + SECS_PER_MIN);
   assign zero_sec_o = value_i - (value_i % SECS_PER_MIN);

endmodule

// File: rtl/time_set_ctrl_m.sv
// Time/alarm setting FSM with registered outputs; define TIME_SET_AUTO_REPEAT_EN
// to add auto-repeat of a held inc button in the SET/ALM states.
module time_set_ctrl_m
   import clock_pkg::*;
#(
   parameter COUNTER_T    COUNTER_MAX   = clock_pkg::COUNTER_MAX,
   parameter int unsigned REPEAT_DELAY  = 8,
   parameter int unsigned REPEAT_PERIOD = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        mode_btn,
   input  logic        inc_btn,
   input  logic [16:0] counter_state,
   input  logic [16:0] alarm_setpoint,
   output logic        load_en,
   output logic [16:0] load_value,
   output logic        alarm_wr_en,
   output logic [16:0] alarm_wr_value,
   output logic        alarm_enable,
   output logic [2:0]  set_mode,
   output logic [16:0] edit_value
);

   if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat_cfg
      $error("time_set_ctrl_m: REPEAT_PERIOD must be in 1..REPEAT_DELAY");
   end

   state_e   state_q, state_d;
   COUNTER_T edit_q, edit_d;
   COUNTER_T load_val_q, load_val_d;
   COUNTER_T alm_val_q, alm_val_d;
   FLAG_T    load_en_q, load_en_d;
   FLAG_T    alm_wr_q, alm_wr_d;
   FLAG_T    alm_en_q, alm_en_d;
   FLAG_T    mode_prev_q, inc_prev_q;

   FLAG_T    mode_edge, inc_edge, inc_fire, rpt_fire;
   COUNTER_T hr_step, min_step, zero_sec;

   assign mode_edge = mode_btn & ~mode_prev_q;
   assign inc_edge  = inc_btn & ~inc_prev_q;
   assign inc_fire  = inc_edge | rpt_fire;

   time_step_m #(
      .MAX_VAL (COUNTER_MAX)
   ) u_step (
      .value_i    (edit_q),
      .hr_step_o  (hr_step),
      .min_step_o (min_step),
      .zero_sec_o (zero_sec)
   );

`ifdef TIME_SET_AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + 1);
   logic [RW-1:0] rpt_q, rpt_d;

   // After the first repeat the counter restarts one period short of the delay.
   always_comb begin
      rpt_d    = '0;
      rpt_fire = 1'b0;
      if (state_q != ST_RUN && !mode_edge && inc_btn && inc_prev_q) begin
         if (rpt_q == RW'(REPEAT_DELAY - 1)) begin
            rpt_fire = 1'b1;
            rpt_d    = RW'(REPEAT_DELAY - REPEAT_PERIOD);
         end else begin
            rpt_d = rpt_q + RW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rpt_q <= '0;
      else          rpt_q <= rpt_d;
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      edit_d     = edit_q;
      load_en_d  = 1'b0;
      load_val_d = load_val_q;
      alm_wr_d   = 1'b0;
      alm_val_d  = alm_val_q;
      alm_en_d   = alm_en_q;
      if (mode_edge) begin
         unique case (state_q)
            ST_RUN: begin
               state_d = ST_SET_HR;
               edit_d  = counter_state;
            end
            ST_SET_HR:  state_d = ST_SET_MIN;
            ST_SET_MIN: begin
               state_d    = ST_ALM_HR;
               load_en_d  = 1'b1;
               load_val_d = zero_sec;
               edit_d     = alarm_setpoint;
            end
            ST_ALM_HR:  state_d = ST_ALM_MIN;
            ST_ALM_MIN: begin
               state_d   = ST_RUN;
               alm_wr_d  = 1'b1;
               alm_val_d = zero_sec;
            end
            default:    state_d = ST_RUN;
         endcase
      end else if (inc_fire) begin
         unique case (state_q)
            ST_RUN:                 alm_en_d = ~alm_en_q;
            ST_SET_HR,  ST_ALM_HR:  edit_d   = hr_step;
            ST_SET_MIN, ST_ALM_MIN: edit_d   = min_step;
            default:                edit_d   = edit_q;
         endcase
      end
   end

   // Previous-sample registers reset high so a button held through reset is not a press.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         edit_q      <= '0;
         load_en_q   <= 1'b0;
         load_val_q  <= '0;
         alm_wr_q    <= 1'b0;
         alm_val_q   <= '0;
         alm_en_q    <= 1'b0;
         mode_prev_q <= 1'b1;
         inc_prev_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         edit_q      <= edit_d;
         load_en_q   <= load_en_d;
         load_val_q  <= load_val_d;
         alm_wr_q    <= alm_wr_d;
         alm_val_q   <= alm_val_d;
         alm_en_q    <= alm_en_d;
         mode_prev_q <= mode_btn;
         inc_prev_q  <= inc_btn;
      end
   end

   assign load_en        = load_en_q;
   assign load_value     = load_val_q;
   assign alarm_wr_en    = alm_wr_q;
   assign alarm_wr_value = alm_val_q;
   assign alarm_enable   = alm_en_q;
   assign set_mode       = state_q;
   assign edit_value     = edit_q;

endmodule

// File: tb/tb_time_set_ctrl_m.sv
// Directed scoreboard bench for time_set_ctrl_m (auto-repeat step follows TIME_SET_AUTO_REPEAT_EN).
module tb_time_set_ctrl_m;

   localparam int SEL_STATE = 0;
   localparam int SEL_EDIT  = 1;
   localparam int SEL_LDEN  = 2;
   localparam int SEL_LDVAL = 3;
   localparam int SEL_AWEN  = 4;
   localparam int SEL_AWVAL = 5;
   localparam int SEL_AEN   = 6;

   typedef struct {
      string       tag;
      int          sel;
      logic [16:0] exp;
   } sb_t;

   logic        clock, reset_n, mode_btn, inc_btn;
   logic [16:0] counter_state, alarm_setpoint;
   logic        load_en, alarm_wr_en, alarm_enable;
   logic [16:0] load_value, alarm_wr_value, edit_value;
   logic [2:0]  set_mode;

   sb_t sb_q[$];
   int  n_eval = 0;
   int  n_fail = 0;

   time_set_ctrl_m dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .mode_btn       (mode_btn),
      .inc_btn        (inc_btn),
      .counter_state  (counter_state),
      .alarm_setpoint (alarm_setpoint),
      .load_en        (load_en),
      .load_value     (load_value),
      .alarm_wr_en    (alarm_wr_en),
      .alarm_wr_value (alarm_wr_value),
      .alarm_enable   (alarm_enable),
      .set_mode       (set_mode),
      .edit_value     (edit_value)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [16:0] observe(input int sel);
      case (sel)
         SEL_STATE: return {14'd0, set_mode};
         SEL_EDIT:  return edit_value;
         SEL_LDEN:  return {16'd0, load_en};
         SEL_LDVAL: return load_value;
         SEL_AWEN:  return {16'd0, alarm_wr_en};
         SEL_AWVAL: return alarm_wr_value;
         default:   return {16'd0, alarm_enable};
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sel, input logic [16:0] exp);
      sb_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic check();
      sb_t         e;
      logic [16:0] obs;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         obs = observe(e.sel);
         n_eval++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic drive(input logic m, input logic i);
      mode_btn = m;
      inc_btn  = i;
      step(1);
   endtask

   task automatic idle();
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      step(1);
   endtask

   initial begin
      reset_n        = 1'b0;
      mode_btn       = 1'b0;
      inc_btn        = 1'b0;
      counter_state  = 17'd45296;
      alarm_setpoint = 17'd25230;
      step(2);
      expect_val("rst_state", SEL_STATE, 17'd0);
      expect_val("rst_edit",  SEL_EDIT,  17'd0);
      expect_val("rst_lden",  SEL_LDEN,  17'd0);
      expect_val("rst_ldval", SEL_LDVAL, 17'd0);
      expect_val("rst_awen",  SEL_AWEN,  17'd0);
      expect_val("rst_awval", SEL_AWVAL, 17'd0);
      expect_val("rst_aen",   SEL_AEN,   17'd0);
      check();
      reset_n = 1'b1;
      step(2);

      // 12:34:56 -> hour+1 -> minute+1 -> commit 13:35:00
      drive(1, 0);
      expect_val("s1_state_hr", SEL_STATE, 17'd1);
      expect_val("s1_edit_cap", SEL_EDIT,  17'd45296);
      check();
      idle();
      counter_state = 17'd100;
      drive(0, 1);
      expect_val("s1_hr_inc", SEL_EDIT, 17'd48896);
      check();
      idle();
      drive(1, 0);
      expect_val("s1_state_min", SEL_STATE, 17'd2);
      expect_val("s1_no_track",  SEL_EDIT,  17'd48896);
      expect_val("s1_no_load",   SEL_LDEN,  17'd0);
      check();
      idle();
      drive(0, 1);
      expect_val("s1_min_inc", SEL_EDIT, 17'd48956);
      check();
      idle();
      drive(1, 0);
      expect_val("s1_load_en",   SEL_LDEN,  17'd1);
      expect_val("s1_load_val",  SEL_LDVAL, 17'd48900);
      expect_val("s1_state_ahr", SEL_STATE, 17'd3);
      expect_val("s1_edit_alm",  SEL_EDIT,  17'd25230);
      expect_val("s1_no_awen",   SEL_AWEN,  17'd0);
      check();
      idle();
      expect_val("s1_load_pulse", SEL_LDEN,  17'd0);
      expect_val("s1_load_hold",  SEL_LDVAL, 17'd48900);
      expect_val("s1_state_hold", SEL_STATE, 17'd3);
      check();

      // Alarm commit with seconds dropped
      drive(1, 0);
      expect_val("alm_state_min", SEL_STATE, 17'd4);
      check();
      idle();
      drive(1, 0);
      expect_val("alm_state_run", SEL_STATE, 17'd0);
      expect_val("alm_wr_en",     SEL_AWEN,  17'd1);
      expect_val("alm_wr_val",    SEL_AWVAL, 17'd25200);
      expect_val("alm_no_load",   SEL_LDEN,  17'd0);
      check();
      idle();
      expect_val("alm_wr_pulse", SEL_AWEN,  17'd0);
      expect_val("alm_wr_hold",  SEL_AWVAL, 17'd25200);
      check();

      // Alarm arm toggle in RUN
      drive(0, 1);
      expect_val("run_aen_on",   SEL_AEN,   17'd1);
      expect_val("run_edit_fix", SEL_EDIT,  17'd25230);
      expect_val("run_lden",     SEL_LDEN,  17'd0);
      expect_val("run_awen",     SEL_AWEN,  17'd0);
      check();
      idle();
      drive(0, 1);
      expect_val("run_aen_off", SEL_AEN,   17'd0);
      expect_val("run_state",   SEL_STATE, 17'd0);
      check();
      idle();

      // 23:36:40 + 1 hour wraps to 00:36:40
      counter_state = 17'd85000;
      drive(1, 0);
      expect_val("wrap_cap", SEL_EDIT, 17'd85000);
      check();
      idle();
      drive(0, 1);
      expect_val("wrap_hr", SEL_EDIT, 17'd2200);
      check();
      idle();
      drive(1, 1);
      expect_val("both_state", SEL_STATE, 17'd2);
      expect_val("both_edit",  SEL_EDIT,  17'd2200);
      check();
      idle();
      drive(1, 0);
      expect_val("wrap_load", SEL_LDVAL, 17'd2160);
      check();
      idle();
      drive(1, 0);
      expect_val("pre_rst_state", SEL_STATE, 17'd4);
      check();
      idle();

      // Reset mid-edit with mode held across release
      mode_btn = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      expect_val("mid_rst_state", SEL_STATE, 17'd0);
      expect_val("mid_rst_awen",  SEL_AWEN,  17'd0);
      expect_val("mid_rst_edit",  SEL_EDIT,  17'd0);
      check();
      step(2);
      reset_n = 1'b1;
      step(2);
      expect_val("held_state", SEL_STATE, 17'd0);
      expect_val("held_awen",  SEL_AWEN,  17'd0);
      expect_val("held_awval", SEL_AWVAL, 17'd0);
      check();
      idle();

      // 01:59:00 minute step wraps to 01:00:00
      counter_state = 17'd7140;
      drive(1, 0);
      idle();
      drive(1, 0);
      idle();
      drive(0, 1);
      expect_val("min59_wrap", SEL_EDIT, 17'd3600);
      check();
      idle();
      drive(1, 0);
      idle();
      drive(1, 0);
      idle();
      drive(1, 0);
      idle();

      // Held inc in SET_MIN starting from 00:00:00
      counter_state = 17'd0;
      drive(1, 0);
      idle();
      drive(1, 0);
      idle();
      expect_val("hold_start", SEL_EDIT, 17'd0);
      check();
      inc_btn = 1'b1;
      step(14);
      inc_btn = 1'b0;
      step(1);
`ifdef TIME_SET_AUTO_REPEAT_EN
      expect_val("hold_repeat", SEL_EDIT, 17'd240);
`else
      expect_val("hold_repeat", SEL_EDIT, 17'd60);
`endif
      expect_val("hold_state", SEL_STATE, 17'd2);
      check();

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule
